// File: rtl/io_uart_pkg.sv
// Shared constants and FSM state codes for the IO-bus UART transmitter.
// Optional parity support is enabled with UART_TX_PARITY_EN.
package io_uart_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;

    localparam int ST_FULL_BIT  = 0;
    localparam int ST_EMPTY_BIT = 1;
    localparam int ST_BUSY_BIT  = 2;
    localparam int ST_OVF_BIT   = 3;
    localparam int ST_COUNT_LSB = 8;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_START  = 3'd1;
    localparam state_t S_DATA   = 3'd2;
    localparam state_t S_PARITY = 3'd3;
    localparam state_t S_STOP   = 3'd4;

endpackage

// File: rtl/io_uart_tx_if.sv
// Processor IO bus as seen by a memory-mapped peripheral.
// Reads are combinational; writes are single-cycle strobes.
interface io_uart_tx_if;

    logic [31:0] IO_memAddr_i;
    logic [31:0] IO_memWData_i;
    logic        IO_memWr_i;
    logic [31:0] IO_memRData_o;

    modport master (
        output IO_memAddr_i,
        output IO_memWData_i,
        output IO_memWr_i,
        input  IO_memRData_o
    );

    modport slave (
        input  IO_memAddr_i,
        input  IO_memWData_i,
        input  IO_memWr_i,
        output IO_memRData_o
    );

endinterface

// File: rtl/io_fifo.sv
// Synchronous FIFO with combinational head and an explicit occupancy count.
// Push when full and pop when empty are ignored.
module io_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [WIDTH-1:0]      wdata_i,
    output logic [WIDTH-1:0]      rdata_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_q;
    logic [DEPTH_LOG2-1:0] rptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  do_push;
    logic                  do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO and programmable divisor.
// Defining UART_TX_PARITY_EN adds a parity bit (BAUDDIV[16] selects odd).
module io_uart_tx
    import io_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h0040_0000,
    parameter int          FIFO_DEPTH_LOG2 = 4,
    parameter logic [15:0] BAUD_DIV_RESET  = 16'd868
) (
    input  logic             clk_i,
    input  logic             reset_i,
    io_uart_tx_if.slave      bus,
    output logic             uart_tx_o
);

    logic                     sel;
    logic [1:0]               off;
    logic                     wr_tx;
    logic                     wr_st;
    logic                     wr_bd;

    logic                     fifo_pop;
    logic [7:0]               fifo_rdata;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [FIFO_DEPTH_LOG2:0] fifo_count;

    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        ovf_q, ovf_d;
    logic [15:0] bauddiv_q, bauddiv_d;
    logic [15:0] dm1;
    logic        bit_end;
    logic        load;
`ifdef UART_TX_PARITY_EN
    logic        par_q, par_d;
    logic        odd_q, odd_d;
`endif

    assign sel   = (bus.IO_memAddr_i[31:4] == BASE_ADDR[31:4]);
    assign off   = bus.IO_memAddr_i[3:2];
    assign wr_tx = bus.IO_memWr_i && sel && (off == REG_TXDATA);
    assign wr_st = bus.IO_memWr_i && sel && (off == REG_STATUS);
    assign wr_bd = bus.IO_memWr_i && sel && (off == REG_BAUDDIV);

    io_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (wr_tx),
        .pop_i   (fifo_pop),
        .wdata_i (bus.IO_memWData_i[7:0]),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // A divisor of 0 behaves as 1 cycle per bit
    assign dm1     = (bauddiv_q == 16'd0) ? 16'd0 : bauddiv_q - 16'd1;
    assign bit_end = (baud_q == 16'd0);

    always_comb begin
        ovf_d     = ovf_q;
        bauddiv_d = bauddiv_q;
`ifdef UART_TX_PARITY_EN
        odd_d     = odd_q;
`endif
        if (wr_tx && fifo_full) begin
            ovf_d = 1'b1;
        end else if (wr_st && bus.IO_memWData_i[ST_OVF_BIT]) begin
            ovf_d = 1'b0;
        end
        if (wr_bd) begin
            bauddiv_d = bus.IO_memWData_i[15:0];
`ifdef UART_TX_PARITY_EN
            odd_d     = bus.IO_memWData_i[16];
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = bit_end ? baud_q : baud_q - 16'd1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        load     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                load = !fifo_empty;
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    baud_d  = dm1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d  = dm1;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    baud_d  = dm1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (fifo_empty) begin
                        state_d = S_IDLE;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Popping from STOP gives back-to-back frames with no idle gap
        if (load) begin
            state_d = S_START;
            baud_d  = dm1;
            bit_d   = 3'd0;
            shift_d = fifo_rdata;
`ifdef UART_TX_PARITY_EN
            par_d   = (^fifo_rdata) ^ odd_q;
`endif
        end
    end

    assign fifo_pop = load;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            baud_q    <= 16'd0;
            bit_q     <= 3'd0;
            shift_q   <= 8'd0;
            ovf_q     <= 1'b0;
            bauddiv_q <= BAUD_DIV_RESET;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
            odd_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            ovf_q     <= ovf_d;
            bauddiv_q <= bauddiv_d;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_d;
            odd_q     <= odd_d;
`endif
        end
    end

    always_comb begin
        unique case (state_q)
            S_START: uart_tx_o = 1'b0;
            S_DATA:  uart_tx_o = shift_q[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: uart_tx_o = par_q;
`endif
            default: uart_tx_o = 1'b1;
        endcase
    end

    always_comb begin
        bus.IO_memRData_o = 32'd0;
        if (sel) begin
            unique case (off)
                REG_STATUS: begin
                    bus.IO_memRData_o[ST_FULL_BIT]  = fifo_full;
                    bus.IO_memRData_o[ST_EMPTY_BIT] = fifo_empty;
                    bus.IO_memRData_o[ST_BUSY_BIT]  = (state_q != S_IDLE);
                    bus.IO_memRData_o[ST_OVF_BIT]   = ovf_q;
                    bus.IO_memRData_o[ST_COUNT_LSB +: FIFO_DEPTH_LOG2+1] =
                        fifo_count;
                end
                REG_BAUDDIV: begin
                    bus.IO_memRData_o[15:0] = bauddiv_q;
`ifdef UART_TX_PARITY_EN
                    bus.IO_memRData_o[16]   = odd_q;
`endif
                end
                default: begin
                    bus.IO_memRData_o = 32'd0;
                end
            endcase
        end
    end

endmodule
